// File: rtl/dense_pkg.sv
// dense_pkg: shared state encoding, activation codes and width helpers for the dense layer.
package dense_pkg;
    typedef enum logic [1:0] {IDLE, MAC, DRAIN, DONE} state_t;
    localparam int ACT_NONE = 0;
    localparam int ACT_RELU = 1;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    // Wide enough for N_IN full products plus the shifted bias without wrapping.
    function automatic int acc_width(input int bitsize, input int n_in);
        return 2 * bitsize + clog2(n_in + 1) + 1;
    endfunction
endpackage

// File: rtl/fxp_requant.sv
// fxp_requant: floor shift by FRAC, saturate to BITSIZE and optional ReLU.
module fxp_requant import dense_pkg::*; #(
    parameter int BITSIZE = 16,
    parameter int FRAC = 8,
    parameter int ACT = ACT_RELU,
    parameter int ACC_W = 37
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic [BITSIZE-1:0]      y
);
    localparam logic signed [ACC_W-1:0] MAX = {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN = {{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
    logic signed [ACC_W-1:0] sh;
    logic [BITSIZE-1:0] sat;
    always_comb begin
        sh = acc >>> FRAC;
        sat = sh > MAX ? MAX[BITSIZE-1:0] : sh < MIN ? MIN[BITSIZE-1:0] : sh[BITSIZE-1:0];
        y = (ACT == ACT_RELU && sat[BITSIZE-1]) ? '0 : sat;
    end
endmodule

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed N_IN x N_OUT fully-connected layer with one shared MAC
// and weights/bias streamed from a registered single-port ROM.
module dense_layer_seq import dense_pkg::*; #(
    parameter int BITSIZE = 16,
    parameter int FRAC = 8,
    parameter int N_IN = 10,
    parameter int N_OUT = 92,
    parameter int ACT = ACT_RELU,
    parameter int AW = clog2(N_OUT * (N_IN + 1))
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [BITSIZE*N_IN-1:0]  x,
    output logic [AW-1:0]            w_addr,
    input  logic [BITSIZE-1:0]       w_data,
    output logic [BITSIZE*N_OUT-1:0] y,
    output logic                     busy,
    output logic                     done
);
    localparam int ACC_W = acc_width(BITSIZE, N_IN);
    localparam int KW = clog2(N_IN + 1);
    localparam int JW = clog2(N_OUT + 1);
    state_t state;
    logic [KW-1:0] k;
    logic [JW-1:0] j;
    logic [BITSIZE*N_IN-1:0] x_q;
    logic signed [ACC_W-1:0] acc, term, acc_next;
    logic signed [BITSIZE-1:0] xi, wd;
    logic signed [2*BITSIZE-1:0] prod;
    logic [BITSIZE-1:0] res;
    int idx;
    // ROM data lags the address by one cycle: MAC step k consumes word k-1, DRAIN consumes the bias.
    always_comb begin
        idx = (k == '0) ? 0 : int'(k) - 1;
        xi = x_q[BITSIZE*idx +: BITSIZE];
        wd = w_data;
        prod = xi * wd;
        term = (state == DRAIN) ? (ACC_W'(wd) <<< FRAC) : ACC_W'(prod);
        acc_next = acc + term;
    end
    fxp_requant #(.BITSIZE(BITSIZE), .FRAC(FRAC), .ACT(ACT), .ACC_W(ACC_W)) u_requant (
        .acc(acc_next),
        .y(res)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k <= '0;
            j <= '0;
            x_q <= '0;
            acc <= '0;
            w_addr <= '0;
            y <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x_q <= x;
                    w_addr <= '0;
                    acc <= '0;
                    k <= '0;
                    j <= '0;
                    busy <= 1'b1;
                    state <= MAC;
                end
                MAC: begin
                    w_addr <= w_addr + 1'b1;
                    if (k != '0) acc <= acc_next;
                    k <= (k == KW'(N_IN)) ? '0 : k + 1'b1;
                    state <= (k == KW'(N_IN)) ? DRAIN : MAC;
                end
                DRAIN: begin
                    y[BITSIZE*j +: BITSIZE] <= res;
                    acc <= '0;
                    j <= j + 1'b1;
                    state <= (j == JW'(N_OUT - 1)) ? DONE : MAC;
                end
                default: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: directed checks of the dense layer against a spec-level arithmetic model.
module tb_dense_layer_seq;
    logic clk = 0, reset = 0, start_s = 0, start_d = 0;
    logic [31:0] x_s = '0;
    logic [159:0] x_d = '0;
    logic [2:0] wa_a, wa_r;
    logic [9:0] wa_d;
    logic [15:0] wd_a = '0, wd_r = '0, wd_d = '0;
    logic [31:0] y_a, y_r;
    logic [1471:0] y_d;
    logic busy_a, busy_r, busy_d, done_a, done_r, done_d;
    logic [15:0] rom_s [0:7];
    logic [15:0] rom_d [0:1023];
    int n_cmp = 0, n_bad = 0;
    localparam logic [31:0] XA = {16'h0200, 16'h0100};
    localparam logic [31:0] XB = {16'h0300, 16'h0100};
    localparam logic [31:0] XC = {16'h7000, 16'h7000};

    always #5 clk = ~clk;

    dense_layer_seq #(.BITSIZE(16), .FRAC(8), .N_IN(2), .N_OUT(2), .ACT(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_s), .x(x_s), .w_addr(wa_a), .w_data(wd_a),
        .y(y_a), .busy(busy_a), .done(done_a));
    dense_layer_seq #(.BITSIZE(16), .FRAC(8), .N_IN(2), .N_OUT(2), .ACT(1)) dut_r (
        .clk(clk), .reset(reset), .start(start_s), .x(x_s), .w_addr(wa_r), .w_data(wd_r),
        .y(y_r), .busy(busy_r), .done(done_r));
    dense_layer_seq dut_d (
        .clk(clk), .reset(reset), .start(start_d), .x(x_d), .w_addr(wa_d), .w_data(wd_d),
        .y(y_d), .busy(busy_d), .done(done_d));

    always @(posedge clk) begin
        wd_a <= rom_s[wa_a];
        wd_r <= rom_s[wa_r];
        wd_d <= rom_d[wa_d];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] requant(input longint s, input int act);
        longint q = s >>> 8;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        if (act == 1 && q < 0) q = 0;
        return 16'(q);
    endfunction

    function automatic longint dot_s(input logic [31:0] xv, input int j);
        longint s = longint'($signed(rom_s[3*j+2])) * 256;
        for (int i = 0; i < 2; i++) s += longint'($signed(xv[16*i +: 16])) * longint'($signed(rom_s[3*j+i]));
        return s;
    endfunction

    function automatic longint dot_d(input int j);
        longint s = longint'($signed(rom_d[11*j+10])) * 256;
        for (int i = 0; i < 10; i++) s += longint'($signed(x_d[16*i +: 16])) * longint'($signed(rom_d[11*j+i]));
        return s;
    endfunction

    // Spec timing: neuron j lands (j+1)*(N_IN+2) edges after accept, done pulses one edge after the last.
    localparam int PER = 4;
    logic m_run = 0, eb = 0, ed = 0;
    int m_cyc = 0;
    logic [31:0] m_x = '0, ey_a = '0, ey_r = '0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run <= 0; m_cyc <= 0; m_x <= '0; eb <= 0; ed <= 0; ey_a <= '0; ey_r <= '0;
        end else if (m_run) begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) % PER == 0 && (m_cyc + 1) / PER <= 2) begin
                ey_a[16*((m_cyc+1)/PER-1) +: 16] <= requant(dot_s(m_x, (m_cyc+1)/PER-1), 0);
                ey_r[16*((m_cyc+1)/PER-1) +: 16] <= requant(dot_s(m_x, (m_cyc+1)/PER-1), 1);
            end
            if (m_cyc + 1 == 2 * PER + 1) begin
                m_run <= 0; eb <= 0; ed <= 1;
            end
        end else begin
            ed <= 0;
            if (start_s) begin
                m_run <= 1; m_cyc <= 0; m_x <= x_s; eb <= 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy_a", 64'(busy_a), 64'(eb));
        chk("done_a", 64'(done_a), 64'(ed));
        chk("busy_r", 64'(busy_r), 64'(eb));
        chk("done_r", 64'(done_r), 64'(ed));
        chk("y_a", 64'(y_a), 64'(ey_a));
        chk("y_r", 64'(y_r), 64'(ey_r));
    end

    task automatic run_s(input logic [31:0] xv, output int lat);
        @(negedge clk); x_s = xv; start_s = 1;
        @(posedge clk); lat = 0;
        @(negedge clk); start_s = 0;
        while (!done_a && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic set_rom(input logic [15:0] a0, a1, a2, a3, a4, a5);
        rom_s[0] = a0; rom_s[1] = a1; rom_s[2] = a2; rom_s[3] = a3; rom_s[4] = a4; rom_s[5] = a5;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, n, first;
        for (int i = 0; i < 8; i++) rom_s[i] = '0;
        for (int i = 0; i < 1024; i++) rom_d[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_y", 64'(y_a), 64'h0);
        chk("rst_busy", 64'(busy_a), 64'h0);
        chk("rst_waddr", 64'(wa_a), 64'h0);
        reset = 1;
        // basic and ReLU
        set_rom(16'h0100, 16'h0100, 16'h0080, 16'hFF00, 16'hFF00, 16'h0000);
        run_s(XA, lat);
        chk("basic_lat", 64'(lat), 64'd9);
        chk("basic_y", 64'(y_a), 64'hFD000380);
        chk("relu_y", 64'(y_r), 64'h00000380);
        // saturation
        set_rom(16'h0200, 16'h0200, 16'h0000, 16'hFE00, 16'hFE00, 16'h0000);
        run_s({16'h7F00, 16'h7F00}, lat);
        chk("sat_y", 64'(y_a), 64'h80007FFF);
        chk("sat_relu_y", 64'(y_r), 64'h00007FFF);
        // stray start mid-run
        set_rom(16'h0100, 16'h0100, 16'h0080, 16'hFF00, 16'hFF00, 16'h0000);
        n = 0; first = 0;
        @(negedge clk); x_s = XA; start_s = 1;
        @(posedge clk);
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk); start_s = (t == 3);
            @(posedge clk); #1;
            if (done_a) begin n++; if (first == 0) first = t; end
        end
        chk("ign_pulses", 64'(n), 64'd1);
        chk("ign_at", 64'(first), 64'd9);
        // start held: second run follows done, x latched only on accept
        @(negedge clk); x_s = XA; start_s = 1;
        @(posedge clk); lat = 0;
        do begin @(negedge clk); if (lat == 4) x_s = XB; @(posedge clk); #1; lat++; end
        while (!done_a && lat < 50);
        chk("held_lat1", 64'(lat), 64'd9);
        chk("held_y1", 64'(y_a), 64'hFD000380);
        @(posedge clk); #1;
        chk("retrigger", 64'(busy_a), 64'h1);
        lat = 0;
        do begin @(negedge clk); start_s = 0; if (lat == 4) x_s = XC; @(posedge clk); #1; lat++; end
        while (!done_a && lat < 50);
        chk("held_lat2", 64'(lat), 64'd9);
        chk("held_y2", 64'(y_a), 64'hFC000480);
        repeat (2) @(posedge clk); #1;
        chk("no_third", 64'(busy_a), 64'h0);
        // asynchronous reset during neuron 1
        @(negedge clk); x_s = XA; start_s = 1;
        @(posedge clk);
        @(negedge clk); start_s = 0;
        repeat (5) @(posedge clk);
        #2 reset = 0; #1;
        chk("abort_y", 64'(y_a), 64'h0);
        chk("abort_busy", 64'(busy_a), 64'h0);
        chk("abort_done", 64'(done_a), 64'h0);
        chk("abort_waddr", 64'(wa_a), 64'h0);
        @(negedge clk); reset = 1;
        run_s(XA, lat);
        chk("after_rst_lat", 64'(lat), 64'd9);
        chk("after_rst_y", 64'(y_a), 64'hFD000380);
        // default 10x92 ReLU against random ROM
        for (int i = 0; i < 10; i++) x_d[16*i +: 16] = 16'((i + 1) * 256);
        for (int a = 0; a < 92 * 11; a++)
            rom_d[a] = (a % 11 == 10) ? 16'($urandom_range(0, 2048)) - 16'd1024 : 16'($urandom_range(0, 128)) - 16'd64;
        @(negedge clk); start_d = 1;
        @(posedge clk); lat = 0;
        @(negedge clk); start_d = 0;
        while (!done_d && lat < 2000) begin @(posedge clk); #1; lat++; end
        chk("dflt_lat", 64'(lat), 64'd1105);
        chk("dflt_busy", 64'(busy_d), 64'h0);
        for (int j = 0; j < 92; j++) chk("dflt_y", 64'(y_d[16*j +: 16]), 64'(requant(dot_d(j), 1)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
